// File: rtl/seq_divider_if.sv
// Request/result bundle for seq_divider: start with operands in, busy/done with results out.
interface seq_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             dz;

  modport master (output start, x, y, input busy, done, q, r, dz);
  modport slave  (input start, x, y, output busy, done, q, r, dz);
endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock; done pulses WIDTH cycles after accept (next cycle for y=0).
// No backpressure: start is taken only while idle (including the done cycle) and ignored while busy.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] pr_q, pr_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] nxt_pr;
  logic [WIDTH-1:0] nxt_dvd;

  always_comb begin
    // The dividend register doubles as the quotient accumulator: bits shift out the top, quotient bits in the bottom.
    trial   = {pr_q, dvd_q[WIDTH-1]};
    diff    = trial - {1'b0, div_q};
    borrow  = diff[WIDTH];
    nxt_pr  = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    nxt_dvd = {dvd_q[WIDTH-2:0], ~borrow};

    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dz_d = 1'b0;
          if (bus.y == '0) begin
            quo_d  = '1;
            rem_d  = bus.x;
            dz_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
            cnt_d   = CW'(WIDTH - 1);
            pr_d    = '0;
            dvd_d   = bus.x;
            div_d   = bus.y;
          end
        end
      end
      RUN: begin
        pr_d  = nxt_pr;
        dvd_d = nxt_dvd;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quo_d   = nxt_dvd;
          rem_d   = nxt_pr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      dvd_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      dvd_q   <= dvd_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.q    = quo_q;
  assign bus.r    = rem_q;
  assign bus.dz   = dz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive checks of seq_divider at WIDTH=4: results, latency, handshake and reset corners.
module tb_seq_divider;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  seq_divider_if #(.WIDTH(W)) ifc ();
  seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Called at the sample point just after an accepting edge; counts edges until done is seen.
  task automatic wait_done(output int cyc, output int bcyc, output bit seen);
    cyc = 0; bcyc = 0; seen = 1'b0;
    while (cyc <= 3 * W) begin
      if (ifc.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (ifc.busy === 1'b1) bcyc++;
      step();
      cyc++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] xv, input logic [W-1:0] yv,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input string nm);
    int cyc, bcyc;
    bit seen;
    ifc.start = 1'b1; ifc.x = xv; ifc.y = yv;
    step();
    ifc.start = 1'b0; ifc.x = ~xv; ifc.y = ~yv;
    wait_done(cyc, bcyc, seen);
    chk({nm, " done seen"}, int'(seen), 1);
    chk({nm, " latency"}, cyc, (yv == '0) ? 0 : W);
    chk({nm, " busy cycles"}, bcyc, (yv == '0) ? 0 : W);
    chk({nm, " busy at done"}, int'(ifc.busy), 0);
    chk({nm, " q"}, int'(ifc.q), int'(eq));
    chk({nm, " r"}, int'(ifc.r), int'(er));
    chk({nm, " dz"}, int'(ifc.dz), int'(edz));
    step();
    chk({nm, " done one cycle"}, int'(ifc.done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, bcyc, dcount;
    bit seen;

    vecs[0]  = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0};
    vecs[1]  = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0};
    vecs[2]  = '{4'd3,  4'd7,  4'd0,  4'd3, 1'b0};
    vecs[3]  = '{4'd5,  4'd0,  4'd15, 4'd5, 1'b1};
    vecs[4]  = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0};
    vecs[5]  = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0};
    vecs[6]  = '{4'd15, 4'd2,  4'd7,  4'd1, 1'b0};
    vecs[7]  = '{4'd8,  4'd3,  4'd2,  4'd2, 1'b0};
    vecs[8]  = '{4'd12, 4'd4,  4'd3,  4'd0, 1'b0};
    vecs[9]  = '{4'd0,  4'd0,  4'd15, 4'd0, 1'b1};
    vecs[10] = '{4'd1,  4'd15, 4'd0,  4'd1, 1'b0};
    vecs[11] = '{4'd14, 4'd5,  4'd2,  4'd4, 1'b0};

    ifc.start = 1'b0; ifc.x = '0; ifc.y = '0;
    #2 rst = 1'b1;
    #1;
    chk("reset busy", int'(ifc.busy), 0);
    chk("reset done", int'(ifc.done), 0);
    chk("reset q", int'(ifc.q), 0);
    chk("reset r", int'(ifc.r), 0);
    chk("reset dz", int'(ifc.dz), 0);
    step(); step();
    @(negedge clk) rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].eq, vecs[i].er, vecs[i].edz, $sformatf("vec%0d", i));
    end

    // Start re-pulsed while busy must be ignored; start held in the done cycle is taken back-to-back.
    ifc.start = 1'b1; ifc.x = 4'd13; ifc.y = 4'd3;
    step();
    ifc.start = 1'b0;
    step();
    ifc.start = 1'b1; ifc.x = 4'd9; ifc.y = 4'd2;
    step();
    ifc.start = 1'b0;
    wait_done(cyc, bcyc, seen);
    chk("busy-start done seen", int'(seen), 1);
    chk("busy-start latency", cyc, W - 2);
    chk("busy-start q", int'(ifc.q), 4);
    chk("busy-start r", int'(ifc.r), 1);
    ifc.start = 1'b1; ifc.x = 4'd9; ifc.y = 4'd2;
    step();
    ifc.start = 1'b0; ifc.x = 4'd0; ifc.y = 4'd0;
    chk("b2b busy", int'(ifc.busy), 1);
    chk("b2b done dropped", int'(ifc.done), 0);
    chk("b2b q held", int'(ifc.q), 4);
    wait_done(cyc, bcyc, seen);
    chk("b2b done seen", int'(seen), 1);
    chk("b2b latency", cyc, W);
    chk("b2b q", int'(ifc.q), 4);
    chk("b2b r", int'(ifc.r), 1);
    step();

    // Asynchronous reset in the middle of a run.
    run_op(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, "pre-abort");
    ifc.start = 1'b1; ifc.x = 4'd13; ifc.y = 4'd3;
    step();
    ifc.start = 1'b0;
    step(); step();
    #2 rst = 1'b1;
    #1;
    chk("abort busy", int'(ifc.busy), 0);
    chk("abort done", int'(ifc.done), 0);
    chk("abort q", int'(ifc.q), 0);
    chk("abort r", int'(ifc.r), 0);
    step();
    @(negedge clk) rst = 1'b0;
    dcount = 0;
    for (int k = 0; k < 2 * W; k++) begin
      step();
      if (ifc.done === 1'b1 || ifc.busy === 1'b1) dcount++;
    end
    chk("abort no done/busy after", dcount, 0);
    run_op(4'd12, 4'd4, 4'd3, 4'd0, 1'b0, "post-abort");

    for (int xi = 0; xi < (1 << W); xi++) begin
      for (int yi = 0; yi < (1 << W); yi++) begin
        run_op(W'(xi), W'(yi),
               (yi == 0) ? {W{1'b1}} : W'(xi / yi),
               (yi == 0) ? W'(xi) : W'(xi % yi),
               (yi == 0), $sformatf("sweep %0d/%0d", xi, yi));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
